// File: rtl/scan_frame_capture.sv
// Scans an 8-way active-low nibble source: steps the select, waits DWELL cycles per slot,
// samples and re-inverts the bus, and publishes the assembled 32-bit frame with a valid pulse.
module scan_frame_capture #(
   parameter int DWELL = 4,
   parameter int DW    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            continuous,
   output logic [2:0]      sel,
   output logic            n_en,
   input  logic [DW-1:0]   din_n,
   output logic [8*DW-1:0] frame,
   output logic            frame_valid,
   output logic            busy
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t            state, state_next;
   logic [CW-1:0]     cnt, cnt_next;
   logic [DW-1:0]     slot_buf [0:6];
   logic [DW-1:0]     buf_next [0:6];
   logic [2:0]        sel_next;
   logic              n_en_next;
   logic              busy_next;
   logic [8*DW-1:0]   frame_next;
   logic              frame_valid_next;
   logic [DW-1:0]     nibble;

   assign nibble = ~din_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         sel         <= '0;
         n_en        <= 1'b1;
         busy        <= 1'b0;
         frame       <= '0;
         frame_valid <= 1'b0;
         for (int k = 0; k < 7; k++) slot_buf[k] <= '0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         sel         <= sel_next;
         n_en        <= n_en_next;
         busy        <= busy_next;
         frame       <= frame_next;
         frame_valid <= frame_valid_next;
         for (int k = 0; k < 7; k++) slot_buf[k] <= buf_next[k];
      end
   end

   // Slot 7 is never buffered: it goes straight into the frame so the update is atomic.
   always_comb begin
      state_next       = state;
      cnt_next         = cnt;
      sel_next         = sel;
      n_en_next        = n_en;
      busy_next        = busy;
      frame_next       = frame;
      frame_valid_next = 1'b0;
      for (int k = 0; k < 7; k++) buf_next[k] = slot_buf[k];

      case (state)
         IDLE: begin
            sel_next  = '0;
            cnt_next  = '0;
            n_en_next = 1'b1;
            busy_next = 1'b0;
            if (start) begin
               state_next = SCAN;
               n_en_next  = 1'b0;
               busy_next  = 1'b1;
            end
         end
         SCAN: begin
            if (cnt != CNT_LAST) begin
               cnt_next = cnt + CW'(1);
            end else begin
               cnt_next = '0;
               for (int k = 0; k < 7; k++) begin
                  if (sel == 3'(k)) buf_next[k] = nibble;
               end
               if (sel == 3'd7) begin
                  for (int k = 0; k < 7; k++) frame_next[k*DW +: DW] = slot_buf[k];
                  frame_next[7*DW +: DW] = nibble;
                  frame_valid_next       = 1'b1;
                  sel_next               = '0;
                  if (!continuous) begin
                     state_next = IDLE;
                     n_en_next  = 1'b1;
                     busy_next  = 1'b0;
                  end
               end else begin
                  sel_next = sel + 3'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: doc/scan_frame_capture.md
Name: scan_frame_capture

Overview:
- Receiving end of the 8-way nibble selector used in the lab designs.
- The selector places one of eight 4-bit values on a shared active-low bus, chosen by a 3-bit select and gated by an active-low enable.
- This block drives select and enable, and waits a settle interval per slot. It then samples the bus, re-inverts it, and assembles the eight nibbles into one 32-bit frame, published with a one-cycle valid pulse.
- It supports single-shot and continuous scanning.

Parameters:
- DWELL, 4: clock cycles each select value is held; the sample is taken on the last of them. Legal range is 1..255.
- DW, 4: nibble width. Fixed at 4 for this design; frame width is 8*DW.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begins a frame scan when sampled high in IDLE.
- continuous  input  1  level; when high at frame completion, the next frame starts immediately.
- sel  output  3  slot select driven to the source.
- n_en  output  1  active-low source enable; 0 while scanning.
- din_n  input  4  active-low nibble bus from the source.
- frame  output  32  last completed frame; slot k occupies bits [4k+3:4k].
- frame_valid  output  1  one-cycle pulse when frame updates.
- busy  output  1  high while in SCAN.

Behaviour:
- Reset is asynchronous and active-low; assertion takes effect immediately, independent of clk. Reset values:
  - state=IDLE, sel=0, n_en=1, busy=0, frame=0, frame_valid=0
  - dwell counter=0, slot buffer=0
- All outputs are registered.
- States: IDLE, SCAN.
- IDLE:
  - n_en=1, sel=0, busy=0.
  - start=1 at edge E: go to SCAN; n_en=0, busy=1, sel=0, cnt=0 after E.
- SCAN, each edge:
  - If cnt<DWELL-1: cnt++.
  - If cnt==DWELL-1: capture ~din_n into buf[sel]; cnt=0.
- After a capture:
  - sel<7: sel++.
  - sel==7: frame <= {~din_n, buf[6:0]} atomically, and frame_valid=1 for exactly one cycle.
    - continuous=1 at that edge: sel wraps to 0 and stays in SCAN; n_en remains 0 with no gap.
    - Otherwise go to IDLE; n_en=1, busy=0, sel=0.
- Latency:
  - Slot k is captured at edge E+(k+1)*DWELL.
  - frame_valid is high in the cycle after edge E+8*DWELL.
  - A continuous scan produces one frame every 8*DWELL cycles.
- DWELL=1: capture every cycle and advance sel every cycle.
- start while in SCAN: ignored; does not restart or extend the frame.
- continuous dropped mid-frame: the current frame completes, then the block returns to IDLE.
- start and continuous both high in IDLE: same as start alone; continuous is only evaluated at frame completion.
- frame holds its value between completions; a partial frame never appears on frame.
- din_n is sampled only at capture edges; its value at other times is don't-care.
- Reset mid-scan: the partial buffer is discarded, frame returns to 0, and no frame_valid is emitted.
- cnt width is max(1, ceil(log2(DWELL))) bits and never exceeds DWELL-1.

Test Plan:
1. Reset released; source slots 0..7 hold 5,A,0,1,7,0,1,2 (driven active-low); DWELL=4; pulse start -> one frame_valid 32 cycles after the start edge, frame=32'h210710A5, then IDLE with n_en=1.
2. DWELL=1, same data, single start -> sel steps 0..7 on consecutive cycles; frame_valid 8 cycles after start; frame=32'h210710A5.
3. continuous=1, DWELL=4; after the first frame change slot 0 to 3 -> frame_valid every 32 cycles with no n_en gap; second frame=32'h210710A3.
4. Pulse start again at slot 3 of an active scan -> no restart; frame_valid still exactly 32 cycles after the original start.
5. Assert rst_n=0 mid-scan at slot 5 -> outputs reset asynchronously (sel=0, n_en=1, frame=0, busy=0); no frame_valid afterwards until a new start.
6. continuous=1, then drop it during slot 2 of the second frame -> second frame completes with one frame_valid, then IDLE with busy=0; no third frame.
